// File: rtl/reg_arb_n.sv
// Shared register written by NREQ channels through an arbiter. Build with REG_ARB_RR_EN
// for round-robin arbitration; otherwise the lowest requesting index wins.
module reg_arb_n #(
    parameter int               WIDTH     = 32,
    parameter int               NREQ      = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*WIDTH-1:0]       wdata,
    input  logic [NREQ*(WIDTH/8)-1:0]   be,
    input  logic                        busy_in,
    output logic [WIDTH-1:0]            data_out,
    output logic [NREQ-1:0]             ack,
    output logic                        busy_out,
    output logic [$clog2(NREQ)-1:0]     grant_id,
    output logic                        fsm_state
);

    localparam int IDW = $clog2(NREQ);
    localparam int BW  = WIDTH / 8;

    typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

    state_t             state;
    logic               found;
    logic [IDW-1:0]     win;
    logic [WIDTH-1:0]   wdata_win;
    logic [BW-1:0]      be_win;
    logic [WIDTH-1:0]   merged;
    logic [NREQ-1:0]    win_onehot;

`ifdef REG_ARB_RR_EN
    logic [IDW-1:0]     ptr;

    // Search starts at the pointer and wraps, so the channel after the last winner goes first.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (int'(ptr) + k) % NREQ;
            if (!found && req[j]) begin
                found = 1'b1;
                win   = IDW'(j);
            end
        end
    end
`else
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[k]) begin
                found = 1'b1;
                win   = IDW'(k);
            end
        end
    end
`endif

    always_comb begin
        wdata_win  = wdata[int'(win)*WIDTH +: WIDTH];
        be_win     = be[int'(win)*BW +: BW];
        win_onehot = NREQ'(1) << win;
        merged     = data_out;
        for (int b = 0; b < BW; b++) begin
            if (be_win[b]) merged[8*b +: 8] = wdata_win[8*b +: 8];
        end
    end

    assign busy_out  = (state == ACK) || busy_in;
    assign fsm_state = state;

    // ACK lasts exactly one cycle and ignores req, so a channel dropping req on its ack
    // can never be written twice.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            data_out <= RESET_VAL;
            ack      <= '0;
            grant_id <= '0;
`ifdef REG_ARB_RR_EN
            ptr      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found && !busy_in) begin
                        data_out <= merged;
                        ack      <= win_onehot;
                        grant_id <= win;
                        state    <= ACK;
`ifdef REG_ARB_RR_EN
                        ptr      <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
`endif
                    end
                end
                ACK: begin
                    ack   <= '0;
                    state <= IDLE;
                end
                default: begin
                    ack   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_arb_n.sv
// Self-checking bench for reg_arb_n: directed scenarios plus random single-channel writes,
// checked against a scoreboard of expected {data, ack, grant_id}. Honours REG_ARB_RR_EN.
module tb_reg_arb_n;

    localparam int W   = 32;
    localparam int N   = 3;
    localparam int IDW = $clog2(N);
    localparam int BW  = W / 8;
    localparam int EW  = W + N + IDW;
    localparam logic [W-1:0] RV = 32'h0;

    logic                clk;
    logic                rst;
    logic [N-1:0]        req;
    logic [N*W-1:0]      wdata;
    logic [N*BW-1:0]     be;
    logic                busy_in;
    logic [W-1:0]        data_out;
    logic [N-1:0]        ack;
    logic                busy_out;
    logic [IDW-1:0]      grant_id;
    logic                fsm_state;

    logic [EW-1:0]       exp_q[$];
    logic [W-1:0]        model_data;
    logic [N-1:0]        prev_ack;
    int                  total;
    int                  bad;

    reg_arb_n #(.WIDTH(W), .NREQ(N), .RESET_VAL(RV)) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata), .be(be), .busy_in(busy_in),
        .data_out(data_out), .ack(ack), .busy_out(busy_out), .grant_id(grant_id),
        .fsm_state(fsm_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got=running exp=done");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic set_ch(input int ch, input logic [W-1:0] d, input logic [BW-1:0] b);
        wdata[ch*W +: W]  = d;
        be[ch*BW +: BW]   = b;
    endtask

    task automatic push_exp(input int ch);
        logic [W-1:0]  d;
        logic [BW-1:0] b;
        logic [N-1:0]  oh;
        d  = wdata[ch*W +: W];
        b  = be[ch*BW +: BW];
        oh = N'(1) << ch;
        for (int k = 0; k < BW; k++) begin
            if (b[k]) model_data[8*k +: 8] = d[8*k +: 8];
        end
        exp_q.push_back({model_data, oh, IDW'(ch)});
    endtask

    // Channels drop req on their ack; a channel in keep_once re-raises once instead.
    task automatic run_drain(input logic [N-1:0] keep_once, input int max_cyc);
        logic [N-1:0] keep;
        int           cyc;
        keep = keep_once;
        cyc  = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    if (keep[i]) keep[i] = 1'b0;
                    else         req[i]  = 1'b0;
                end
            end
            if (req == '0 && exp_q.size() == 0) break;
            if (cyc >= max_cyc) begin
                check("drain_timeout", 64'(cyc), 64'(max_cyc + 1));
                req = '0;
                break;
            end
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst) begin
            check("ack_onehot", 64'($countones(ack) <= 1), 64'd1);
            if (ack != '0) begin
                logic [EW-1:0] e;
                check("ack_gap", 64'(prev_ack), 64'd0);
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_ack", 64'(ack), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", 64'(data_out), 64'(e[EW-1 -: W]));
                    check("sb_ack",  64'(ack),      64'(e[IDW +: N]));
                    check("sb_gid",  64'(grant_id), 64'(e[IDW-1:0]));
                end
            end
            prev_ack = ack;
        end else begin
            prev_ack = '0;
        end
    end

    initial begin
        logic [W-1:0]  saved;
        logic [W-1:0]  rd;
        logic [BW-1:0] rb;
        int            ch;

        total = 0; bad = 0;
        rst = 1'b0; req = '0; wdata = '0; be = '0; busy_in = 1'b0;
        model_data = RV; prev_ack = '0;

        #12;
        check("rst_data", 64'(data_out), 64'(RV));
        check("rst_ack",  64'(ack),      64'd0);
        check("rst_gid",  64'(grant_id), 64'd0);
        check("rst_busy", 64'(busy_out), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // single write
        @(negedge clk);
        set_ch(0, 32'hDEADBEEF, 4'b1111);
        req = 3'b001;
        push_exp(0);
        @(negedge clk);
        check("single_ack",  64'(ack),      64'd1);
        check("single_data", 64'(data_out), 64'hDEADBEEF);
        check("single_gid",  64'(grant_id), 64'd0);
        check("busy_in_ack", 64'(busy_out), 64'd1);
        req = '0;
        @(negedge clk);
        check("single_ack_clr", 64'(ack), 64'd0);

        // partial write
        set_ch(1, 32'h12345678, 4'b0101);
        req = 3'b010;
        push_exp(1);
        @(negedge clk);
        check("partial_data", 64'(data_out), 64'hDE34BE78);
        check("partial_ack",  64'(ack),      64'd2);
        req = '0;
        @(negedge clk);

        // downstream hold
        busy_in = 1'b1;
        set_ch(2, 32'hCAFEF00D, 4'b1100);
        req = 3'b100;
        push_exp(2);
        #1 check("hold_busy_now", 64'(busy_out), 64'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("hold_no_ack", 64'(ack),      64'd0);
            check("hold_busy",   64'(busy_out), 64'd1);
        end
        busy_in = 1'b0;
        @(negedge clk);
        check("hold_release_ack", 64'(ack), 64'd4);
        req = '0;
        @(negedge clk);

        // contention, channel 0 re-raises once after its first ack
        set_ch(0, 32'h11111111, 4'b1111);
        set_ch(1, 32'h22222222, 4'b0011);
        set_ch(2, 32'h33333333, 4'b1000);
        req = 3'b111;
`ifdef REG_ARB_RR_EN
        push_exp(0); push_exp(1); push_exp(2); push_exp(0);
`else
        push_exp(0); push_exp(0); push_exp(1); push_exp(2);
`endif
        run_drain(3'b001, 40);
        @(negedge clk);
        check("contend_sb_empty", 64'(exp_q.size()), 64'd0);

        // zero enables
        saved = model_data;
        set_ch(0, 32'hFFFFFFFF, 4'b0000);
        req = 3'b001;
        push_exp(0);
        @(negedge clk);
        check("zero_be_ack",  64'(ack),      64'd1);
        check("zero_be_data", 64'(data_out), 64'(saved));
        req = '0;
        @(negedge clk);

        // reset during ACK
        set_ch(0, 32'hA5A5A5A5, 4'b1111);
        req = 3'b001;
        push_exp(0);
        @(negedge clk);
        check("mid_pre_ack", 64'(ack), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_ack",  64'(ack),      64'd0);
        check("mid_rst_data", 64'(data_out), 64'(RV));
        check("mid_rst_gid",  64'(grant_id), 64'd0);
        model_data = RV;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        set_ch(1, 32'h0BADCAFE, 4'b1111);
        req = 3'b010;
        push_exp(1);
        @(negedge clk);
        check("first_grant_ack", 64'(ack), 64'd2);
        req = '0;
        @(negedge clk);
        check("no_replay_ack", 64'(ack), 64'd0);

        // random single-channel writes
        for (int t = 0; t < 10; t++) begin
            ch = $urandom_range(0, N - 1);
            rd = $urandom;
            rb = BW'($urandom_range(0, (1 << BW) - 1));
            set_ch(ch, rd, rb);
            req = N'(1) << ch;
            push_exp(ch);
            @(negedge clk);
            req = '0;
            @(negedge clk);
        end

        repeat (2) @(negedge clk);
        check("sb_empty_final", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
